// File: rtl/gcd_pkg.sv
// Shared GCD types: operand width and engine state encoding.
// Used by the engine, the operand capture stage and the display driver.
package gcd_pkg;

  localparam int GCD_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_step.sv
// One Euclid subtract-and-compare step; purely combinational, zero latency.
// No backpressure: outputs follow x/y directly.
module gcd_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] nx,
  output logic [W-1:0] ny,
  output logic         term,
  output logic [W-1:0] term_val
);

  always_comb begin
    term     = (y == '0) || (x == '0) || (x == y);
    // When y is zero the answer is x; when only x is zero it is y.
    term_val = (y == '0) ? x : ((x == '0) ? y : x);
    nx       = x;
    ny       = y;
    if (x > y) begin
      nx = x - y;
    end else begin
      ny = y - x;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative subtract-and-compare GCD; optional GCD_ITER_CNT_EN adds a step counter.
// Latency 2 + S cycles (S = subtraction steps); start ignored unless IDLE, no queuing.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic             res_rdy
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [WIDTH:0]   iter_cnt
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, y, x_nxt, y_nxt, res_nxt;
  logic [WIDTH-1:0] nx, ny, term_val;
  logic             term;

  gcd_step #(.W(WIDTH)) u_step (
    .x        (x),
    .y        (y),
    .nx       (nx),
    .ny       (ny),
    .term     (term),
    .term_val (term_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    res_nxt   = res;
    case (state)
      IDLE: begin
        if (start) begin
          x_nxt     = a;
          y_nxt     = b;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (term) begin
          res_nxt   = term_val;
          state_nxt = DONE;
        end else begin
          x_nxt = nx;
          y_nxt = ny;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      res <= '0;
    end else begin
      x   <= x_nxt;
      y   <= y_nxt;
      res <= res_nxt;
    end
  end

  // Pure state decodes keep busy/res_rdy free of input-to-output paths.
  assign busy    = (state == CALC);
  assign res_rdy = (state == DONE);

`ifdef GCD_ITER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      iter_cnt <= '0;
    end else if ((state == CALC) && !term) begin
      iter_cnt <= iter_cnt + {{WIDTH{1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed-vector bench for gcd_engine; expected results and latencies are hand-computed.
module tb_gcd_engine;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy;
  logic [W-1:0] res;
  logic         res_rdy;
`ifdef GCD_ITER_CNT_EN
  logic [W:0]   iter_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .res     (res),
    .res_rdy (res_rdy)
`ifdef GCD_ITER_CNT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns just after the accepting edge.
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the start edge; lat counts edges including the start edge.
  task automatic wait_rdy(output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (!res_rdy && lat < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || res_rdy !== 1'b0 || res !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b res_rdy=%b res=%0d, required 0/0/0", busy, res_rdy, res);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || res_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b res_rdy=%b, required 0/0", busy, res_rdy);
    end
  endtask

  task automatic test_equal;
    int lat, bc;
    do_start(5'd31, 5'd31);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL equal_busy_after_start: busy=%b, required 1", busy);
    end
    wait_rdy(lat, bc);
    n_checks++;
    if (res !== 5'd31 || lat != 2 || bc != 1) begin
      n_fail++;
      $display("FAIL equal_31_31: res=%0d lat=%0d busy_cyc=%0d, required 31/2/1", res, lat, bc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL equal_busy_in_done: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_rdy !== 1'b0 || res !== 5'd31) begin
      n_fail++;
      $display("FAIL equal_pulse_hold: res_rdy=%b res=%0d, required 0/31", res_rdy, res);
    end
  endtask

  task automatic test_steps;
    int lat, bc;
    do_start(5'd12, 5'd18);
    wait_rdy(lat, bc);
    n_checks++;
    if (res !== 5'd6 || lat != 4 || bc != 3) begin
      n_fail++;
      $display("FAIL steps_12_18: res=%0d lat=%0d busy_cyc=%0d, required 6/4/3", res, lat, bc);
    end
`ifdef GCD_ITER_CNT_EN
    n_checks++;
    if (iter_cnt !== 6'd2) begin
      n_fail++;
      $display("FAIL steps_iter_cnt: got %0d, required 2", iter_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int lat, bc;
    do_start(5'd0, 5'd20);
    wait_rdy(lat, bc);
    n_checks++;
    if (res !== 5'd20 || lat != 2) begin
      n_fail++;
      $display("FAIL zero_0_20: res=%0d lat=%0d, required 20/2", res, lat);
    end
    @(posedge clk); #1;
    do_start(5'd0, 5'd0);
    wait_rdy(lat, bc);
    n_checks++;
    if (res !== 5'd0 || lat != 2) begin
      n_fail++;
      $display("FAIL zero_0_0: res=%0d lat=%0d, required 0/2", res, lat);
    end
`ifdef GCD_ITER_CNT_EN
    n_checks++;
    if (iter_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL zero_iter_cnt: got %0d, required 0", iter_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  // Worst case, with start pulses and operand changes injected mid-CALC.
  task automatic test_long;
    int lat;
    do_start(5'd31, 5'd1);
    lat = 1;
    while (!res_rdy && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1;
        a = 5'd7;
        b = 5'd14;
      end else if (lat == 7) begin
        start = 1'b0;
        a = 5'd3;
      end
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (res !== 5'd1 || lat != 32) begin
      n_fail++;
      $display("FAIL long_31_1: res=%0d lat=%0d, required 1/32", res, lat);
    end
`ifdef GCD_ITER_CNT_EN
    n_checks++;
    if (iter_cnt !== 6'd30) begin
      n_fail++;
      $display("FAIL long_iter_cnt: got %0d, required 30", iter_cnt);
    end
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || res_rdy !== 1'b0 || res !== 5'd1) begin
      n_fail++;
      $display("FAIL long_no_queue: busy=%b res_rdy=%b res=%0d, required 0/0/1", busy, res_rdy, res);
    end
  endtask

  task automatic test_mid_reset;
    int lat, bc, pulses;
    do_start(5'd31, 5'd1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || res !== 5'd0 || res_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: busy=%b res=%0d res_rdy=%b, required 0/0/0", busy, res, res_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (res_rdy || busy) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: active cycles=%0d, required 0", pulses);
    end
    do_start(5'd8, 5'd12);
    wait_rdy(lat, bc);
    n_checks++;
    if (res !== 5'd4 || lat != 4) begin
      n_fail++;
      $display("FAIL after_reset_8_12: res=%0d lat=%0d, required 4/4", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int p[3];
    int np;
    np = 0;
    a = 5'd9;
    b = 5'd6;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (res_rdy) begin
        if (np < 3) p[np] = c;
        np++;
        n_checks++;
        if (res !== 5'd3) begin
          n_fail++;
          $display("FAIL b2b_res: cycle %0d res=%0d, required 3", c, res);
        end
      end else if (np > 0) begin
        n_checks++;
        if (res !== 5'd3) begin
          n_fail++;
          $display("FAIL b2b_res_stable: cycle %0d res=%0d, required 3", c, res);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (np < 3) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d pulses, required at least 3", np);
    end else if (p[0] != 4 || p[1] != 9 || p[2] != 14) begin
      n_fail++;
      $display("FAIL b2b_pulse_times: got %0d/%0d/%0d, required 4/9/14", p[0], p[1], p[2]);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_steps();
    test_zero();
    test_long();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
